regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 22 ++
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard_entry.sv | 37 +++
 rtl/regfile_scoreboard.sv | 120 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared scoreboard types: pending-write counter and the decode-stage issue request.
// Imported by the scoreboard top, its interface and the per-register counter.
package common;

   localparam int REGISTER_FILE_SIZE = 32;
   localparam int REG_ID_W           = 5;

   typedef logic [1:0] sb_count_t;

   localparam sb_count_t SB_COUNT_MAX = 2'd3;

   typedef struct packed {
      logic [REG_ID_W-1:0] rs1_id;
      logic [REG_ID_W-1:0] rs2_id;
      logic [REG_ID_W-1:0] rd_id;
      logic                rs1_used;
      logic                rs2_used;
      logic                rd_write;
      logic                long_op;
   } sb_issue_req_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode <-> scoreboard signal bundle.
// master = decode/writeback side, slave = scoreboard.
interface regfile_scoreboard_if
   import common::*;
#(
   parameter int NUM_REGS    = REGISTER_FILE_SIZE,
   parameter int STALL_CNT_W = 16
);
   logic                   issue_valid;
   logic [REG_ID_W-1:0]    rs1_id;
   logic [REG_ID_W-1:0]    rs2_id;
   logic                   rs1_used;
   logic                   rs2_used;
   logic [REG_ID_W-1:0]    rd_id;
   logic                   rd_write;
   logic                   long_op;
   logic                   flush;
   logic                   wb_valid;
   logic [REG_ID_W-1:0]    wb_id;
   logic                   issue_ready;
   logic                   stall;
   logic [NUM_REGS-1:0]    busy_vec;
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic                   wb_underflow;

   modport master (
      output issue_valid, rs1_id, rs2_id, rs1_used, rs2_used,
             rd_id, rd_write, long_op, flush, wb_valid, wb_id,
      input  issue_ready, stall, busy_vec, stall_cycles, wb_underflow
   );

   modport slave (
      input  issue_valid, rs1_id, rs2_id, rs1_used, rs2_used,
             rd_id, rd_write, long_op, flush, wb_valid, wb_id,
      output issue_ready, stall, busy_vec, stall_cycles, wb_underflow
   );

endinterface

// File: rtl/regfile_scoreboard_entry.sv
// sb_entry: one register's saturating 2-bit pending-write counter.
// A matched inc/dec pair cancels; a lone dec at zero is ignored and flagged.
module sb_entry
   import common::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      inc,
   input  logic      dec,
   output sb_count_t count,
   output logic      underflow
);

   sb_count_t count_reg;
   sb_count_t count_next;

   always_comb begin
      count_next = count_reg;
      if (inc && !dec && count_reg != SB_COUNT_MAX) begin
         count_next = count_reg + 2'd1;
      end else if (dec && !inc && count_reg != '0) begin
         count_next = count_reg - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count     = count_reg;
   assign underflow = dec && !inc && (count_reg == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: RAW/WAW/capacity hazard detection for long-latency ops.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a count-1 hazard.
module regfile_scoreboard
   import common::*;
#(
   parameter int NUM_REGS    = REGISTER_FILE_SIZE,
   parameter int STALL_CNT_W = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   regfile_scoreboard_if.slave sb
);

   localparam int ID_SPACE = 1 << REG_ID_W;

   sb_issue_req_t          req;
   sb_count_t              count_arr [ID_SPACE];
   logic [ID_SPACE-1:0]    underflow_vec;
   sb_count_t              rs1_cnt;
   sb_count_t              rs2_cnt;
   sb_count_t              rd_cnt;
   logic                   rs1_bypass;
   logic                   rs2_bypass;
   logic                   rd_bypass;
   logic                   raw_hazard;
   logic                   waw_hazard;
   logic                   cap_hazard;
   logic                   issue_fire;
   logic                   stall_int;
   logic [NUM_REGS-1:0]    busy_vec;
   logic [STALL_CNT_W-1:0] stall_cycles_reg;
   logic                   wb_underflow_reg;

   always_comb begin
      req          = '0;
      req.rs1_id   = sb.rs1_id;
      req.rs2_id   = sb.rs2_id;
      req.rd_id    = sb.rd_id;
      req.rs1_used = sb.rs1_used;
      req.rs2_used = sb.rs2_used;
      req.rd_write = sb.rd_write;
      req.long_op  = sb.long_op;
   end

   // Ids outside 1..NUM_REGS-1 read as a permanently idle counter.
   for (genvar gi = 0; gi < ID_SPACE; gi++) begin : g_entry
      if (gi == 0 || gi >= NUM_REGS) begin : g_untracked
         assign count_arr[gi]     = '0;
         assign underflow_vec[gi] = 1'b0;
      end else begin : g_tracked
         logic inc;
         logic dec;

         assign inc = issue_fire && req.rd_write && req.long_op &&
                      (req.rd_id == REG_ID_W'(gi));
         assign dec = sb.wb_valid && (sb.wb_id == REG_ID_W'(gi));

         sb_entry u_entry (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc),
            .dec       (dec),
            .count     (count_arr[gi]),
            .underflow (underflow_vec[gi])
         );
      end
   end

   assign rs1_cnt = count_arr[req.rs1_id];
   assign rs2_cnt = count_arr[req.rs2_id];
   assign rd_cnt  = count_arr[req.rd_id];

`ifdef SCOREBOARD_WB_BYPASS_EN
   // Register file writes before it reads, so the retiring value is visible now.
   assign rs1_bypass = sb.wb_valid && (sb.wb_id == req.rs1_id) && (rs1_cnt == 2'd1);
   assign rs2_bypass = sb.wb_valid && (sb.wb_id == req.rs2_id) && (rs2_cnt == 2'd1);
   assign rd_bypass  = sb.wb_valid && (sb.wb_id == req.rd_id)  && (rd_cnt  == 2'd1);
`else
   assign rs1_bypass = 1'b0;
   assign rs2_bypass = 1'b0;
   assign rd_bypass  = 1'b0;
`endif

   assign raw_hazard = (req.rs1_used && (rs1_cnt != '0) && !rs1_bypass) ||
                       (req.rs2_used && (rs2_cnt != '0) && !rs2_bypass);
   assign waw_hazard = req.rd_write && (req.rd_id != '0) && (rd_cnt != '0) && !rd_bypass;
   assign cap_hazard = req.rd_write && req.long_op && (rd_cnt == SB_COUNT_MAX);

   assign sb.issue_ready = !sb.issue_valid || !(raw_hazard || waw_hazard || cap_hazard);
   assign stall_int      = sb.issue_valid && !sb.issue_ready && !sb.flush;
   assign issue_fire     = sb.issue_valid && sb.issue_ready && !sb.flush;
   assign sb.stall       = stall_int;

   always_comb begin
      busy_vec = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         busy_vec[i] = (count_arr[i] != '0);
      end
   end

   assign sb.busy_vec = busy_vec;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cycles_reg <= '0;
         wb_underflow_reg <= 1'b0;
      end else begin
         if (stall_int && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
         end
         if (|underflow_vec) begin
            wb_underflow_reg <= 1'b1;
         end
      end
   end

   assign sb.stall_cycles = stall_cycles_reg;
   assign sb.wb_underflow = wb_underflow_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: long-op RAW, reg 0, saturation, flush,
// stall counter saturation and mid-stall reset.
module tb_regfile_scoreboard;
   import common::*;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.NUM_REGS(32), .STALL_CNT_W(16)) sb_bus ();

   regfile_scoreboard #(.NUM_REGS(32), .STALL_CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sb      (sb_bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s value=%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sb_bus.issue_valid = 1'b0;
      sb_bus.rs1_id      = '0;
      sb_bus.rs2_id      = '0;
      sb_bus.rs1_used    = 1'b0;
      sb_bus.rs2_used    = 1'b0;
      sb_bus.rd_id       = '0;
      sb_bus.rd_write    = 1'b0;
      sb_bus.long_op     = 1'b0;
      sb_bus.flush       = 1'b0;
      sb_bus.wb_valid    = 1'b0;
      sb_bus.wb_id       = '0;
   endtask

   task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                          input logic wr, input logic lo);
      sb_bus.issue_valid = 1'b1;
      sb_bus.rs1_id      = rs1;
      sb_bus.rs1_used    = u1;
      sb_bus.rs2_id      = '0;
      sb_bus.rs2_used    = 1'b0;
      sb_bus.rd_id       = rd;
      sb_bus.rd_write    = wr;
      sb_bus.long_op     = lo;
      sb_bus.flush       = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle();
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      do_reset();
      check("reset_ready", 32'(sb_bus.issue_ready), 32'd1);
      check("reset_stall", 32'(sb_bus.stall), 32'd0);
      check("reset_busy", sb_bus.busy_vec, 32'd0);
      check("reset_stall_cycles", 32'(sb_bus.stall_cycles), 32'd0);
      check("reset_underflow", 32'(sb_bus.wb_underflow), 32'd0);

      // Long-op load to r5 followed by a dependent add.
      present(5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      #1;
      check("load_ready", 32'(sb_bus.issue_ready), 32'd1);
      tick();
      present(5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      #1;
      check("raw_busy", sb_bus.busy_vec, 32'h20);
      check("raw_ready", 32'(sb_bus.issue_ready), 32'd0);
      check("raw_stall", 32'(sb_bus.stall), 32'd1);
      tick();
      check("raw_stall_cycles", 32'(sb_bus.stall_cycles), 32'd1);
      sb_bus.wb_valid = 1'b1;
      sb_bus.wb_id    = 5'd5;
      #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      check("wb_cycle_ready", 32'(sb_bus.issue_ready), 32'd1);
`else
      check("wb_cycle_ready", 32'(sb_bus.issue_ready), 32'd0);
`endif
      tick();
      sb_bus.wb_valid = 1'b0;
      #1;
      check("after_wb_ready", 32'(sb_bus.issue_ready), 32'd1);
      check("after_wb_busy", sb_bus.busy_vec, 32'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      check("after_wb_stall_cycles", 32'(sb_bus.stall_cycles), 32'd1);
`else
      check("after_wb_stall_cycles", 32'(sb_bus.stall_cycles), 32'd2);
`endif
      tick();
      idle();

      // Register 0 is never tracked.
      present(5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      #1;
      check("r0_load_ready", 32'(sb_bus.issue_ready), 32'd1);
      tick();
      present(5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
      #1;
      check("r0_busy", sb_bus.busy_vec, 32'd0);
      check("r0_reader_ready", 32'(sb_bus.issue_ready), 32'd1);
      tick();
      idle();

      // Preload r7 to the maximum pending count.
      force dut.g_entry[7].g_tracked.u_entry.count_reg = 2'd3;
      tick();
      release dut.g_entry[7].g_tracked.u_entry.count_reg;
      #1;
      check("sat_busy", sb_bus.busy_vec, 32'h80);
      present(5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      sb_bus.wb_valid = 1'b1;
      sb_bus.wb_id    = 5'd7;
      #1;
      check("sat_ready", 32'(sb_bus.issue_ready), 32'd0);
      check("sat_stall", 32'(sb_bus.stall), 32'd1);
      tick();
      check("sat_wb_count", 32'(dut.g_entry[7].g_tracked.u_entry.count_reg), 32'd2);
      sb_bus.issue_valid = 1'b0;
      tick();
      tick();
      check("sat_drained", 32'(dut.g_entry[7].g_tracked.u_entry.count_reg), 32'd0);
      sb_bus.issue_valid = 1'b1;
      #1;
      check("inc_dec_ready", 32'(sb_bus.issue_ready), 32'd1);
      tick();
      idle();
      #1;
      check("inc_dec_count", 32'(dut.g_entry[7].g_tracked.u_entry.count_reg), 32'd0);
      check("inc_dec_busy", sb_bus.busy_vec, 32'd0);
      do_reset();

      // Flushed long op must not leave a pending write.
      present(5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      sb_bus.flush = 1'b1;
      #1;
      check("flush_ready", 32'(sb_bus.issue_ready), 32'd1);
      check("flush_stall", 32'(sb_bus.stall), 32'd0);
      tick();
      idle();
      #1;
      check("flush_busy", sb_bus.busy_vec, 32'd0);
      sb_bus.wb_valid = 1'b1;
      sb_bus.wb_id    = 5'd9;
      tick();
      idle();
      #1;
      check("underflow_set", 32'(sb_bus.wb_underflow), 32'd1);
      check("underflow_busy", sb_bus.busy_vec, 32'd0);
      repeat (3) tick();
      check("underflow_sticky", 32'(sb_bus.wb_underflow), 32'd1);

      // Long stall saturates the counter, then reset mid-stall.
      present(5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      present(5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      repeat (70000) tick();
      check("stall_sat", 32'(sb_bus.stall_cycles), 32'hFFFF);
      check("stall_sat_stall", 32'(sb_bus.stall), 32'd1);
      reset_n = 1'b0;
      tick();
      check("midrst_stall_cycles", 32'(sb_bus.stall_cycles), 32'd0);
      check("midrst_busy", sb_bus.busy_vec, 32'd0);
      check("midrst_underflow", 32'(sb_bus.wb_underflow), 32'd0);
      check("midrst_ready", 32'(sb_bus.issue_ready), 32'd1);
      check("midrst_stall", 32'(sb_bus.stall), 32'd0);
      reset_n = 1'b1;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
